// File: rtl/rwl_bitserial_drv_if.sv
// rwl_bitserial_drv_if: vector handshake in, bit-plane beats and sideband out
interface rwl_bitserial_drv_if #(
  parameter int ACT_W = 8,
  parameter int NROW  = 8
);
  localparam int IW = $clog2(ACT_W);
  logic                  in_valid;
  logic                  in_ready;
  logic [NROW*ACT_W-1:0] in_act;
  logic                  in_bank;
  logic                  in_xsigned;
  logic                  in_sus;
  logic [NROW-1:0]       nX0;
  logic [NROW-1:0]       nX1;
  logic                  sus;
  logic                  bit_valid;
  logic                  bit_ready;
  logic [IW-1:0]         bit_idx;
  logic                  bit_first;
  logic                  bit_last;
  logic                  bit_neg;
  logic                  busy;
  modport master (
    output in_valid, in_act, in_bank, in_xsigned, in_sus, bit_ready,
    input  in_ready, nX0, nX1, sus, bit_valid, bit_idx, bit_first, bit_last, bit_neg, busy
  );
  modport slave (
    input  in_valid, in_act, in_bank, in_xsigned, in_sus, bit_ready,
    output in_ready, nX0, nX1, sus, bit_valid, bit_idx, bit_first, bit_last, bit_neg, busy
  );
endinterface

// File: rtl/rwl_bitserial_drv.sv
// rwl_bitserial_drv: serialises activation vectors LSB-first onto the inverted MAC paths
module rwl_bitserial_drv #(
  parameter int ACT_W = 8,
  parameter int NROW  = 8
) (
  input logic               clk,
  input logic               rst,
  rwl_bitserial_drv_if.slave bus
);
  localparam int IW = $clog2(ACT_W);
  localparam logic [IW-1:0] LAST = IW'(ACT_W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                          state_q, state_d;
  logic [NROW-1:0][ACT_W-1:0]      act_q, act_d;
  logic                            bank_q, bank_d, xs_q, xs_d, sus_q, sus_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [NROW-1:0]                 nx0_q, nx0_d, nx1_q, nx1_d, plane;
  logic                            first_q, first_d, last_q, last_d, neg_q, neg_d;
  logic                            in_ready, fire, acc, shift;
  assign in_ready = (state_q == IDLE) || (last_q && bus.bit_ready);
  assign fire     = (state_q == SHIFT) && bus.bit_ready;
  assign acc      = bus.in_valid && in_ready;
  // outputs are computed from next-state so every beat leaves a flop directly
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    bank_d  = bank_q;
    xs_d    = xs_q;
    sus_d   = sus_q;
    idx_d   = idx_q;
    plane   = '0;
    if (acc) begin
      state_d = SHIFT;
      act_d   = bus.in_act;
      bank_d  = bus.in_bank;
      xs_d    = bus.in_xsigned;
      sus_d   = bus.in_sus;
      idx_d   = '0;
    end else if (fire) begin
      state_d = last_q ? IDLE : SHIFT;
      idx_d   = last_q ? '0 : idx_q + 1'b1;
    end
    for (int r = 0; r < NROW; r++) plane[r] = act_d[r][idx_d];
    shift   = state_d == SHIFT;
    nx0_d   = (shift && !bank_d) ? ~plane : '1;
    nx1_d   = (shift && bank_d) ? ~plane : '1;
    first_d = shift && idx_d == '0;
    last_d  = shift && idx_d == LAST;
    neg_d   = last_d && xs_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      bank_q  <= 1'b0;
      xs_q    <= 1'b0;
      sus_q   <= 1'b0;
      idx_q   <= '0;
      nx0_q   <= '1;
      nx1_q   <= '1;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      bank_q  <= bank_d;
      xs_q    <= xs_d;
      sus_q   <= sus_d;
      idx_q   <= idx_d;
      nx0_q   <= nx0_d;
      nx1_q   <= nx1_d;
      first_q <= first_d;
      last_q  <= last_d;
      neg_q   <= neg_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.nX0       = nx0_q;
  assign bus.nX1       = nx1_q;
  assign bus.sus       = sus_q;
  assign bus.bit_valid = state_q == SHIFT;
  assign bus.bit_idx   = idx_q;
  assign bus.bit_first = first_q;
  assign bus.bit_last  = last_q;
  assign bus.bit_neg   = neg_q;
  assign bus.busy      = state_q == SHIFT;
endmodule

// File: doc/rwl_bitserial_drv.md
# rwl_bitserial_drv

Bit-serial activation driver feeding the local MAC's inverted activation ports (nX0/nX1). It accepts one vector of NROW multi-bit activations per handshake and presents it LSB-first, one bit-plane per beat. The active bank's path carries ~X, and the inactive path is forced to all-ones so the OAI product on that path is zero. Per-beat sideband (bit index, first/last, negative-weight flag) goes downstream for the shift-accumulator that consumes mac_out.

## Interface
- ACT_W, 8, activation width in bits (≥2); beats per vector
- NROW, 8, rows per vector; equals the local MAC's nX width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  activation vector valid
- in_ready  out  1  driver can accept a vector this cycle
- in_act  in  NROW*ACT_W  activations; row r at [r*ACT_W +: ACT_W]
- in_bank  in  1  0 = drive path 0 (Bank 0), 1 = drive path 1 (Bank 1)
- in_xsigned  in  1  activations are two's complement
- in_sus  in  1  weight signed/unsigned mode, forwarded to the MAC
- nX0  out  NROW  ~X bit-plane for path 0 (all-ones when masked)
- nX1  out  NROW  ~X bit-plane for path 1 (all-ones when masked)
- sus  out  1  latched in_sus for the current vector
- bit_valid  out  1  current beat is valid
- bit_ready  in  1  downstream has consumed the current beat
- bit_idx  out  clog2(ACT_W)  bit position of the current beat
- bit_first  out  1  current beat is bit 0
- bit_last  out  1  current beat is bit ACT_W-1
- bit_neg  out  1  current beat's weight is −2^bit_idx (in_xsigned & bit_last)
- busy  out  1  a vector is in flight

## Operation
- State machine:
  - IDLE: bit_valid=0, nX0=nX1=all-ones, in_ready=1.
  - On in_valid & in_ready, latch in_act, in_bank, in_xsigned and in_sus, clear the counter, and go to SHIFT.
- SHIFT, beat k (k = bit_idx):
  - Active path = ~{act[r][k]} for r = 0..NROW-1.
  - Inactive path = all-ones.
  - bit_valid=1.
- Advance:
  - A beat completes when bit_valid & bit_ready.
  - On completion, k increments, but only if k < ACT_W-1.
- End of vector, when beat ACT_W-1 completes:
  - If in_valid is high in the same cycle, the next vector is accepted and its bit 0 appears on the next beat with no bubble. in_ready = bit_last & bit_ready in SHIFT.
  - Otherwise the driver returns to IDLE.
- Stall: while bit_valid & ~bit_ready, every output holds its value.
- No beat is dropped and none is repeated.
- in_ready is 0 in SHIFT except in the completing last beat.
- Inputs changing mid-vector have no effect, because all vector fields are latched at acceptance.
- bit_neg is asserted only on bit_last of a vector accepted with in_xsigned=1, so the downstream accumulator subtracts that partial sum.
- sus is constant for the whole vector and changes only at the acceptance edge.
- The masked path never carries a 0. Both paths are never driven active in the same beat.
- busy = (state == SHIFT).

## Timing
- Reset values:
  - nX0 = nX1 = {NROW{1}}
  - bit_valid = 0, bit_idx = 0, bit_first = bit_last = bit_neg = 0
  - sus = 0, busy = 0, in_ready = 1
- Every output except in_ready is registered; in_ready is combinational from state, bit_last and bit_ready.
- Latency: a vector accepted at edge T presents bit 0 in the cycle after T, i.e. outputs update at edge T.
- Throughput: one vector per ACT_W cycles when bit_ready stays high and in_valid is back-to-back.
- Reset mid-vector: the next edge with rst=1 returns to IDLE with reset values. The partial vector is discarded and no bit_last is emitted.
- rst has priority over a simultaneous handshake.
- in_valid without in_ready does not latch; upstream holds its data.

## Test plan
- Reset/idle:
  - Stimulus: assert rst for 2 cycles, then idle 5 cycles.
  - Required: nX0 = nX1 = 8'hFF, bit_valid = 0, in_ready = 1 throughout.
- Single vector, bank 0:
  - Stimulus: row0 = 8'hA5, other rows 0, in_bank = 0, in_xsigned = 0, bit_ready = 1.
  - Required: nX0[0] over beats 0..7 = 0,1,0,1,1,0,1,0. nX0[7:1] = 7'h7F. nX1 = 8'hFF for all beats.
  - Required: bit_first on beat 0 only, bit_last on beat 7 only, bit_neg = 0.
- Bank 1 masking, signed:
  - Stimulus: all rows 8'h80, in_bank = 1, in_xsigned = 1.
  - Required: nX0 = 8'hFF every beat. nX1 = 8'hFF on beats 0..6 and 8'h00 on beat 7. bit_neg = 1 only on beat 7.
- Back-to-back:
  - Stimulus: two vectors (8'h01 then 8'hFF, bank 0), with in_valid held.
  - Required: 16 consecutive valid beats with no bubble. The second vector is accepted in the cycle of the first vector's bit_last. sus switches exactly at that boundary.
- Stall:
  - Stimulus: bit_ready = 0 on beats 3 and 4 for 3 cycles each.
  - Required: outputs frozen during each stall. The full sequence matches the no-stall case. in_ready = 0 during the stalls.
- Reset mid-vector:
  - Stimulus: assert rst on beat 4 of a vector.
  - Required: the next cycle shows reset values with no bit_last. A new vector then starts at bit_idx = 0.
